// File: rtl/sa_drain_ctrl.sv
// Drains the systolic array's result columns (SIZE-1 down to 0) into the output buffer over valid/ready.
// Optional macro SA_DRAIN_RELU_EN clamps negative signed elements to zero on capture.
module sa_drain_ctrl #(
    parameter int WIDTH = 8,
    parameter int SIZE  = 32
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [SIZE-1:0][WIDTH-1:0]       sa_data_out,
    output logic [SIZE-1:0]                  sa_carry_en,
    output logic                             ob_valid,
    input  logic                             ob_ready,
    output logic [SIZE-1:0][WIDTH-1:0]       ob_data,
    output logic [$clog2(SIZE)-1:0]          ob_col,
    output logic                             busy,
    output logic                             done
);

    localparam int COL_W = $clog2(SIZE);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SIZE - 1);
    localparam logic [COL_W-1:0] ONE_COL  = COL_W'(1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        PRESENT = 3'd2,
        SHIFT   = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                       state_q;
    logic [COL_W-1:0]             k_q;
    logic                         carry_q;
    logic                         valid_q;
    logic [SIZE-1:0][WIDTH-1:0]   data_q;
    logic [COL_W-1:0]             col_q;
    logic                         busy_q;
    logic                         done_q;
    logic [SIZE-1:0][WIDTH-1:0]   capture_d;

`ifdef SA_DRAIN_RELU_EN
    function automatic logic [WIDTH-1:0] relu_elem(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        if (v[WIDTH-1]) begin
            r = '0;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Capture value for LOAD: negative elements clamp to zero
    always_comb begin
        capture_d = '0;
        for (int r = 0; r < SIZE; r++) begin
            capture_d[r] = relu_elem(sa_data_out[r]);
        end
    end
`else
    // Capture value for LOAD: elements pass bit-exact
    always_comb begin
        capture_d = sa_data_out;
    end
`endif

    // Drain sequencer with registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            carry_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            col_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    carry_q <= 1'b0;
                    done_q  <= 1'b0;
                    if (start) begin
                        k_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                LOAD: begin
                    data_q  <= capture_d;
                    col_q   <= LAST_COL - k_q;
                    valid_q <= 1'b1;
                    state_q <= PRESENT;
                end
                PRESENT: begin
                    // Hold the beat stable until the buffer takes it
                    if (ob_ready) begin
                        valid_q <= 1'b0;
                        if (k_q == LAST_COL) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            carry_q <= 1'b1;
                            state_q <= SHIFT;
                        end
                    end else begin
                        valid_q <= 1'b1;
                        state_q <= PRESENT;
                    end
                end
                SHIFT: begin
                    carry_q <= 1'b0;
                    k_q     <= k_q + ONE_COL;
                    state_q <= LOAD;
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    k_q     <= '0;
                    carry_q <= 1'b0;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign sa_carry_en = {SIZE{carry_q}};
    assign ob_valid    = valid_q;
    assign ob_data     = data_q;
    assign ob_col      = col_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_sa_drain_ctrl.sv
// Self-checking bench for sa_drain_ctrl: array model, scoreboard of expected beats, table of drain scenarios.
module tb_sa_drain_ctrl;

    localparam int WIDTH = 8;
    localparam int SIZE  = 4;

    logic                        clock = 1'b0;
    logic                        reset = 1'b1;
    logic                        start = 1'b0;
    logic                        ob_ready = 1'b1;
    logic [SIZE-1:0][WIDTH-1:0]  sa_data_out;
    logic [SIZE-1:0][WIDTH-1:0]  ob_data;
    logic [SIZE-1:0]             sa_carry_en;
    logic                        ob_valid;
    logic                        busy;
    logic                        done;
    logic [1:0]                  ob_col;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] arr [SIZE][SIZE];
    int cur = SIZE - 1;

    typedef struct {
        logic [1:0]            col;
        logic [SIZE*WIDTH-1:0] data;
    } beat_t;
    beat_t sbq[$];
    beat_t mon_b;

    typedef struct {
        int stall_col;
        int stall_len;
        bit hold;
        int exp_done;
    } vec_t;
    vec_t vecs[5];

    sa_drain_ctrl #(.WIDTH(WIDTH), .SIZE(SIZE)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .sa_data_out (sa_data_out),
        .sa_carry_en (sa_carry_en),
        .ob_valid    (ob_valid),
        .ob_ready    (ob_ready),
        .ob_data     (ob_data),
        .ob_col      (ob_col),
        .busy        (busy),
        .done        (done)
    );

    always #5 clock = ~clock;

    always_comb begin
        sa_data_out = '0;
        for (int r = 0; r < SIZE; r++) sa_data_out[r] = arr[cur][r];
    end

    // Array model: a new drain reloads the last column, each carry pulse shifts one column toward the output
    always @(posedge clock) begin
        if (reset) cur <= SIZE - 1;
        else if (start && !busy) cur <= SIZE - 1;
        else if (sa_carry_en[0] && cur > 0) cur <= cur - 1;
    end

    function automatic logic [WIDTH-1:0] model_elem(input logic [WIDTH-1:0] v);
`ifdef SA_DRAIN_RELU_EN
        return v[WIDTH-1] ? 8'h00 : v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every accepted beat must match the next expected one
    always @(negedge clock) begin
        if (!reset && ob_valid && ob_ready) begin
            if (sbq.size() == 0) begin
                check("sb_unexpected_beat", 64'd1, 64'd0);
            end else begin
                mon_b = sbq.pop_front();
                check("sb_col", 64'(ob_col), 64'(mon_b.col));
                check("sb_data", 64'(ob_data), 64'(mon_b.data));
            end
        end
    end

    task automatic push_beats();
        beat_t b;
        for (int k = 0; k < SIZE; k++) begin
            b.col  = 2'(SIZE - 1 - k);
            b.data = '0;
            for (int r = 0; r < SIZE; r++) b.data[r*WIDTH +: WIDTH] = model_elem(arr[SIZE-1-k][r]);
            sbq.push_back(b);
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        check({nm, "_carry"}, 64'(sa_carry_en), 64'd0);
        check({nm, "_valid"}, 64'(ob_valid), 64'd0);
        check({nm, "_data"}, 64'(ob_data), 64'd0);
        check({nm, "_col"}, 64'(ob_col), 64'd0);
        check({nm, "_busy"}, 64'(busy), 64'd0);
        check({nm, "_done"}, 64'(done), 64'd0);
    endtask

    // Entered #1 after a clock edge (cycle 0); start is driven in cycle 0
    task automatic run_drain(input int stall_col, input int stall_len, input bit hold, input int exp_done);
        int stalled = 0;
        int carries = 0;
        int dones = 0;
        int done_at = -1;
        int first_valid = -1;
        bit data_ok = 1'b1;
        logic [SIZE-1:0][WIDTH-1:0] held = '0;
        push_beats();
        start = 1'b1;
        ob_ready = 1'b1;
        for (int c = 1; c <= exp_done + 1; c++) begin
            @(posedge clock);
            #1;
            if (!hold || c > exp_done) start = 1'b0;
            if (sa_carry_en != '0) begin
                carries++;
                if (sa_carry_en != '1) data_ok = 1'b0;
            end
            if (done) begin
                dones++;
                done_at = c;
            end
            if (ob_valid && first_valid < 0) first_valid = c;
            if (ob_valid && int'(ob_col) == stall_col && stalled < stall_len) begin
                if (stalled == 0) held = ob_data;
                else if (ob_data !== held || sa_carry_en != '0) data_ok = 1'b0;
                ob_ready = 1'b0;
                stalled++;
            end else begin
                ob_ready = 1'b1;
            end
        end
        check("done_cycle", 64'(done_at), 64'(exp_done));
        check("done_pulses", 64'(dones), 64'd1);
        check("carry_pulses", 64'(carries), 64'(SIZE - 1));
        check("first_valid_cycle", 64'(first_valid), 64'd2);
        check("stall_stable", 64'(data_ok), 64'd1);
        check("stall_len", 64'(stalled), 64'(stall_len));
        check("idle_after_done", 64'(busy), 64'd0);
        repeat (2) @(posedge clock);
        #1;
        check("no_queued_drain", 64'(busy), 64'd0);
        check("sb_drained", 64'(sbq.size()), 64'd0);
    endtask

    initial begin
        int dones;
        bit seen;
        vecs[0] = '{stall_col: -1, stall_len: 0, hold: 1'b0, exp_done: 12};
        vecs[1] = '{stall_col:  2, stall_len: 5, hold: 1'b0, exp_done: 17};
        vecs[2] = '{stall_col:  3, stall_len: 2, hold: 1'b0, exp_done: 14};
        vecs[3] = '{stall_col:  0, stall_len: 1, hold: 1'b0, exp_done: 13};
        vecs[4] = '{stall_col: -1, stall_len: 0, hold: 1'b1, exp_done: 12};
        for (int c = 0; c < SIZE; c++)
            for (int r = 0; r < SIZE; r++)
                arr[c][r] = 8'((SIZE - 1 - c) * SIZE + r + 1);

        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        @(posedge clock);
        #1;

        for (int i = 0; i < 5; i++) run_drain(vecs[i].stall_col, vecs[i].stall_len, vecs[i].hold, vecs[i].exp_done);

        // Reset asserted mid-cycle while beat col 2 is presented
        push_beats();
        while (sbq.size() > 1) void'(sbq.pop_back());
        start = 1'b1;
        ob_ready = 1'b1;
        seen = 1'b0;
        for (int c = 1; c < 40 && !seen; c++) begin
            @(posedge clock);
            #1;
            start = 1'b0;
            if (ob_valid && ob_col == 2'd2) begin
                ob_ready = 1'b0;
                seen = 1'b1;
            end
        end
        check("reach_col2", 64'(seen), 64'd1);
        #3;
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
        ob_ready = 1'b1;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clock);
            #1;
            if (done || busy) dones++;
        end
        check("no_done_after_reset", 64'(dones), 64'd0);
        check("sb_after_reset", 64'(sbq.size()), 64'd0);
        run_drain(-1, 0, 1'b0, 12);

        // Sign-boundary data through the capture path
        for (int c = 0; c < SIZE; c++)
            for (int r = 0; r < SIZE; r++)
                arr[c][r] = r[0] ? 8'h7F : 8'hF0;
        run_drain(-1, 0, 1'b0, 12);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
